// File: rtl/sram_like_responder.sv
// SRAM-like slave: accepts req/addr_ok handshakes onto a single-port RAM and
// answers with data_ok/rdata in request order, with run-time programmable stalls.
module sram_like_responder #(
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned RAM_AW      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [3:0]        wstrb,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [2:0]        cfg_addr_lat,
   input  logic [2:0]        cfg_data_lat
);

   localparam int unsigned PW = $clog2(OUTSTANDING);

   logic [2:0]    wait_cnt;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] rd_idx;
   logic [PW:0]   occ;
   logic          rd_pend;

   logic          q_wr   [OUTSTANDING];
   logic [31:0]   q_data [OUTSTANDING];
   logic          q_cap  [OUTSTANDING];
   logic [2:0]    q_age  [OUTSTANDING];

   logic          full;
   logic          push;
   logic          pop;
   logic          head_valid;
   logic          bypass;
   logic          head_cap;
   logic [31:0]   head_data;
   logic [2:0]    data_lat_eff;
   logic          unused_ok;

   assign full    = (occ == (PW+1)'(OUTSTANDING));
   assign addr_ok = req & ~full & (wait_cnt >= cfg_addr_lat) & ~reset;
   assign push    = addr_ok;

   assign ram_en    = addr_ok;
   assign ram_we    = (addr_ok & wr) ? wstrb : '0;
   assign ram_addr  = addr[RAM_AW+1:2];
   assign ram_wdata = wdata;

   // Read data lands in the queue one cycle after the handshake; forwarding it
   // straight from the RAM lets a zero-latency read answer in that same cycle.
   assign bypass       = rd_pend & (rd_idx == head);
   assign head_valid   = (occ != '0);
   assign head_cap     = q_cap[head] | bypass;
   assign head_data    = bypass ? ram_rdata : q_data[head];
   assign data_lat_eff = (cfg_data_lat == 3'd0) ? 3'd1 : cfg_data_lat;

   assign data_ok = head_valid & head_cap & (q_age[head] >= data_lat_eff) & ~reset;
   assign pop     = data_ok;
   assign rdata   = (data_ok & ~q_wr[head]) ? head_data : '0;

   assign unused_ok = ^{size, addr[1:0], addr[31:RAM_AW+2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         head     <= '0;
         tail     <= '0;
         occ      <= '0;
         rd_pend  <= 1'b0;
         rd_idx   <= '0;
         for (int unsigned i = 0; i < OUTSTANDING; i++) begin
            q_wr[i]   <= 1'b0;
            q_data[i] <= '0;
            q_cap[i]  <= 1'b0;
            q_age[i]  <= '0;
         end
      end else begin
         if (!req || push)
            wait_cnt <= '0;
         else if (wait_cnt != 3'd7)
            wait_cnt <= wait_cnt + 3'd1;

         for (int unsigned i = 0; i < OUTSTANDING; i++) begin
            if (q_age[i] != 3'd7)
               q_age[i] <= q_age[i] + 3'd1;
         end

         if (rd_pend) begin
            q_data[rd_idx] <= ram_rdata;
            q_cap[rd_idx]  <= 1'b1;
         end
         rd_pend <= push & ~wr;
         rd_idx  <= tail;

         // Age is stored one ahead so it reads as "cycles since accept" when compared.
         if (push) begin
            q_wr[tail]   <= wr;
            q_data[tail] <= '0;
            q_cap[tail]  <= wr;
            q_age[tail]  <= 3'd1;
            tail         <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;

         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: logs accepts/responses per cycle and
// compares them to hand-computed cycle offsets and data.
module tb_sram_like_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [2:0]  cfg_addr_lat;
   logic [2:0]  cfg_data_lat;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] mem [0:1023];

   int          acc_q [$];
   int          rsp_c [$];
   logic [31:0] rsp_d [$];

   logic        r_wr    [16];
   logic [31:0] r_addr  [16];
   logic [31:0] r_wdata [16];
   logic [3:0]  r_wstrb [16];

   always #5 clk = ~clk;

   sram_like_responder #(.OUTSTANDING(4), .RAM_AW(16)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .cfg_addr_lat(cfg_addr_lat), .cfg_data_lat(cfg_data_lat)
   );

   // Synchronous single-port RAM, read-before-write, data one cycle after ram_en.
   always @(posedge clk) begin
      if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr[9:0]];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (addr_ok) acc_q.push_back(cyc);
      if (data_ok) begin
         rsp_c.push_back(cyc);
         rsp_d.push_back(rdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      acc_q.delete();
      rsp_c.delete();
      rsp_d.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds req for each entry of r_* until accepted; start = cycle of first req.
   task automatic send(input int n, output int start);
      int i = 0;
      int guard = 0;
      @(posedge clk);
      #1;
      start = cyc;
      while (i < n && guard < 100) begin
         req = 1'b1; wr = r_wr[i]; addr = r_addr[i]; wdata = r_wdata[i]; wstrb = r_wstrb[i];
         @(negedge clk);
         if (addr_ok) i++;
         @(posedge clk);
         #1;
         guard++;
      end
      req = 1'b0; wr = 1'b0; wstrb = '0;
      if (i < n) check("send_timeout", i, n);
   endtask

   task automatic set_read(input int idx, input logic [31:0] a);
      r_wr[idx] = 1'b0; r_addr[idx] = a; r_wdata[idx] = 32'h0; r_wstrb[idx] = 4'h0;
   endtask

   int t0;

   initial begin
      reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = '0; addr = '0; wdata = '0;
      cfg_addr_lat = '0; cfg_data_lat = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'h55;
      mem[64] = 32'hFFFF_FFFF;
      for (int i = 0; i < 12; i++) mem[100+i] = 32'h1000 + i;

      // Reset state with a request pending
      repeat (3) @(posedge clk);
      #1;
      req = 1'b1;
      @(negedge clk);
      check("rst_addr_ok", addr_ok, 0);
      check("rst_data_ok", data_ok, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0; req = 1'b0;

      // Zero latency: three reads back-to-back
      clear_logs();
      set_read(0, 32'h0); set_read(1, 32'h4); set_read(2, 32'h8);
      send(3, t0);
      idle(4);
      check("zl_acc_n", acc_q.size(), 3);
      check("zl_rsp_n", rsp_c.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("zl_acc_cyc", acc_q[i] - t0, i);
         check("zl_rsp_cyc", rsp_c[i] - t0, i + 1);
      end
      check("zl_rd0", rsp_d[0], 32'h11);
      check("zl_rd1", rsp_d[1], 32'h22);
      check("zl_rd2", rsp_d[2], 32'h33);

      // Address stall of 3; wait counter restarts after each handshake
      clear_logs();
      cfg_addr_lat = 3'd3; cfg_data_lat = 3'd0;
      set_read(0, 32'h8); set_read(1, 32'hC);
      send(2, t0);
      idle(4);
      check("as_acc_n", acc_q.size(), 2);
      check("as_acc0", acc_q[0] - t0, 3);
      check("as_acc1", acc_q[1] - t0, 7);
      check("as_rsp0", rsp_c[0] - t0, 4);
      check("as_rsp1", rsp_c[1] - t0, 8);
      check("as_rd0", rsp_d[0], 32'h33);
      check("as_rd1", rsp_d[1], 32'h44);

      // Full queue: fifth read waits for the cycle after the first response
      clear_logs();
      cfg_addr_lat = 3'd0; cfg_data_lat = 3'd7;
      for (int i = 0; i < 5; i++) set_read(i, 32'(4 * i));
      send(5, t0);
      idle(10);
      check("fu_acc_n", acc_q.size(), 5);
      check("fu_rsp_n", rsp_c.size(), 5);
      for (int i = 0; i < 4; i++) begin
         check("fu_acc_cyc", acc_q[i] - t0, i);
         check("fu_rsp_cyc", rsp_c[i] - t0, i + 7);
      end
      check("fu_acc4", acc_q[4] - t0, 8);
      check("fu_rsp4", rsp_c[4] - t0, 15);
      check("fu_rd0", rsp_d[0], 32'h11);
      check("fu_rd3", rsp_d[3], 32'h44);
      check("fu_rd4", rsp_d[4], 32'h55);

      // Byte-masked write followed by read of the same word
      clear_logs();
      cfg_addr_lat = 3'd0; cfg_data_lat = 3'd0;
      r_wr[0] = 1'b1; r_addr[0] = 32'h100; r_wdata[0] = 32'hDEAD_BEEF; r_wstrb[0] = 4'b0011;
      set_read(1, 32'h100);
      send(2, t0);
      idle(3);
      check("wr_rsp_n", rsp_c.size(), 2);
      check("wr_rsp0_cyc", rsp_c[0] - t0, 1);
      check("wr_rsp1_cyc", rsp_c[1] - t0, 2);
      check("wr_rdata0", rsp_d[0], 32'h0);
      check("wr_rdata1", rsp_d[1], 32'hFFFF_BEEF);
      check("wr_mem", mem[64], 32'hFFFF_BEEF);

      // Steady push+pop at occupancy 3 with pointer wrap
      clear_logs();
      cfg_addr_lat = 3'd0; cfg_data_lat = 3'd3;
      for (int i = 0; i < 12; i++) set_read(i, 32'h190 + 32'(4 * i));
      send(12, t0);
      idle(5);
      check("wp_acc_n", acc_q.size(), 12);
      check("wp_rsp_n", rsp_c.size(), 12);
      for (int i = 0; i < 12; i++) begin
         check("wp_acc_cyc", acc_q[i] - t0, i);
         check("wp_rsp_cyc", rsp_c[i] - t0, i + 3);
         check("wp_rdata", rsp_d[i], 32'h1000 + 32'(i));
      end

      // Reset with three outstanding reads
      clear_logs();
      cfg_addr_lat = 3'd0; cfg_data_lat = 3'd7;
      for (int i = 0; i < 3; i++) set_read(i, 32'(4 * i));
      send(3, t0);
      reset = 1'b1; req = 1'b1; addr = 32'h4;
      @(negedge clk);
      check("mr_addr_ok", addr_ok, 0);
      check("mr_data_ok", data_ok, 0);
      check("mr_ram_en", ram_en, 0);
      check("mr_ram_we", ram_we, 0);
      check("mr_rdata", rdata, 0);
      idle(2);
      reset = 1'b0; req = 1'b0;
      clear_logs();
      idle(12);
      check("mr_no_rsp", rsp_c.size(), 0);
      check("mr_no_acc", acc_q.size(), 0);
      cfg_data_lat = 3'd1;
      set_read(0, 32'h4);
      send(1, t0);
      idle(3);
      check("mr_new_acc", acc_q[0] - t0, 0);
      check("mr_new_rsp", rsp_c[0] - t0, 1);
      check("mr_new_rd", rsp_d[0], 32'h22);
      check("mr_new_n", rsp_c.size(), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Slave end of the SRAM-like request/response interface that the fetch and memory stages drive: accepts `req`/`addr_ok` handshakes, performs the access on a synchronous single-port RAM, and returns `data_ok`/`rdata` strictly in request order. Acceptance and response latencies are programmable at run time, so the initiators can be exercised against a stalling memory. It sits between a pipeline stage's SRAM-like port and the block RAM model in the SoC top.

## Interface
- `OUTSTANDING`, 4, maximum accepted-but-unanswered requests (power of two, ≥2)
- `RAM_AW`, 16, RAM word-address width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  request valid; held by master until `addr_ok`
- `wr`  in  1  1 = write, 0 = read
- `size`  in  2  access size; recorded, not used for data steering
- `wstrb`  in  4  byte write enables (writes only)
- `addr`  in  32  byte address
- `wdata`  in  32  write data
- `addr_ok`  out  1  request accepted this cycle (combinational)
- `data_ok`  out  1  one response returned this cycle (single-cycle pulse per request)
- `rdata`  out  32  read data, valid with `data_ok`; 0 for write responses
- `ram_en`  out  1  RAM access enable
- `ram_we`  out  4  RAM byte write enables
- `ram_addr`  out  RAM_AW  RAM word address = `addr[RAM_AW+1:2]`
- `ram_wdata`  out  32  RAM write data
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en`
- `cfg_addr_lat`  in  3  min cycles `req` is held before `addr_ok`
- `cfg_data_lat`  in  3  min cycles from accept to `data_ok` (0 treated as 1)

## Operation
- Accept: `wait_cnt` (3 bits, saturating at 7) increments each cycle `req`=1 and no handshake; clears when `req`=0 or on handshake.
- `addr_ok = req & ~full & (wait_cnt >= cfg_addr_lat) & ~reset`. With `cfg_addr_lat`=0, `addr_ok` can rise the same cycle as `req`.
- `full` = occupancy == OUTSTANDING. No push-while-full, even if a pop occurs that cycle.
- Handshake cycle: `ram_en`=1, `ram_we` = `wr ? wstrb : 0`, `ram_addr`/`ram_wdata` from request; push entry {wr, data=0, captured=wr, age=0} at tail. Outside handshakes, `ram_en`=0 and `ram_we`=0.
- Cycle after a read handshake: `ram_rdata` is written into that entry and `captured` is set.
- Age: every valid entry's 3-bit age increments each cycle, saturating at 7.
- Response: `data_ok = head_valid & head.captured & (head.age >= max(1, cfg_data_lat))`; `rdata` = head.data (0 for writes); head popped the same cycle. Master cannot back-pressure; `data_ok` is never held.
- Push and pop are allowed in the same cycle (occupancy unchanged). Pointers are log2(OUTSTANDING) bits and wrap naturally; occupancy is log2(OUTSTANDING)+1 bits.
- Config inputs may change at any time and take effect immediately; already-eligible responses are not retracted.
- Reset: queue empty, pointers, occupancy, `wait_cnt` and all ages 0; `addr_ok`, `data_ok`, `ram_en`, `ram_we` = 0; `rdata` = 0. Reset mid-transaction drops all outstanding entries with no response.

## Timing
- Accept latency: `cfg_addr_lat` cycles of held `req` (0 = same cycle).
- Response latency: accept in cycle T → earliest `data_ok` in T+max(1, `cfg_data_lat`). At most one `data_ok` per cycle.
- Back-to-back: with both latencies 0, one accept and one response per cycle; throughput is 1 request/cycle.
- `data_ok` and `rdata` depend only on registered state plus the `cfg_data_lat` input; there is no combinational path from `req`.
- Ordering: responses are strictly FIFO; reads and writes share the queue.

## Test plan
- Zero latency: cfg 0/0, reads of addr 0x0, 0x4, 0x8 (RAM preloaded 0x11, 0x22, 0x33) → `addr_ok` in T, T+1, T+2; `data_ok` in T+1..T+3 with rdata 0x11, 0x22, 0x33.
- Addr stall: cfg_addr_lat=3, `req` held from cycle 10 → `addr_ok` exactly at cycle 13; `wait_cnt` clears afterward.
- Full: cfg_data_lat=7, 5 back-to-back reads → 4 accepted; `addr_ok`=0 for the 5th until the first `data_ok` (accept+7), then accepted the cycle after.
- Write then read: write 0xDEADBEEF, wstrb=4'b0011, to 0x100 (old 0xFFFFFFFF); then read 0x100 → write response with rdata 0; read response 0xFFFFBEEF, in order.
- Simultaneous push/pop at full occupancy minus one, with pointer wrap over 10+ transactions → occupancy correct, no lost or reordered responses.
- Reset with 3 outstanding requests → no further `data_ok`; all outputs 0 during reset; a new read after reset returns correctly.
